// File: rtl/fp16_div_seq.sv
// Sequential FP16 divider (restoring, one quotient bit per cycle, fixed 16-cycle latency).
// Define FP16_DIV_RNE_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fp16_div_seq #(
  parameter logic [15:0] CANON_NAN = 16'h7E00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        overflow,
  output logic        zero,
  output logic        nan,
  output logic        div_by_zero,
  output logic        precision_lost
);

  typedef enum logic [2:0] {IDLE, CHECK, DIVIDE, ROUND, DONE} state_t;

  state_t             state;
  logic [15:0]        op_a, op_b;
  logic [11:0]        rem;
  logic [12:0]        q;
  logic [3:0]         cnt;
  logic signed [6:0]  exp_q;
  logic               sign_q;
  logic               spec_valid;
  logic [15:0]        spec_res;
  logic [4:0]         spec_flags;
  logic [4:0]         flags;

  // flags are packed {overflow, zero, nan, div_by_zero, precision_lost}
  assign {overflow, zero, nan, div_by_zero, precision_lost} = flags;

  // Operand classification; subnormals count as zero because only the exponent is tested.
  logic [10:0] mb;
  logic        sgn_s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  assign mb     = {1'b1, op_b[9:0]};
  assign sgn_s  = op_a[15] ^ op_b[15];
  assign a_zero = (op_a[14:10] == 5'd0);
  assign b_zero = (op_b[14:10] == 5'd0);
  assign a_inf  = (op_a[14:10] == 5'h1F) && (op_a[9:0] == 10'd0);
  assign b_inf  = (op_b[14:10] == 5'h1F) && (op_b[9:0] == 10'd0);
  assign a_nan  = (op_a[14:10] == 5'h1F) && (op_a[9:0] != 10'd0);
  assign b_nan  = (op_b[14:10] == 5'h1F) && (op_b[9:0] != 10'd0);

  logic        spec_s;
  logic [15:0] spec_res_s;
  logic [4:0]  spec_flags_s;

  // Special-case outcome selection
  always_comb begin
    spec_s       = 1'b1;
    spec_res_s   = 16'h0000;
    spec_flags_s = 5'b00000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res_s   = CANON_NAN;
      spec_flags_s = 5'b00100;
    end else if (a_inf) begin
      spec_res_s   = {sgn_s, 5'h1F, 10'h000};
    end else if (b_zero) begin
      spec_res_s   = {sgn_s, 5'h1F, 10'h000};
      spec_flags_s = 5'b00010;
    end else if (a_zero || b_inf) begin
      spec_res_s   = {sgn_s, 15'h0000};
      spec_flags_s = 5'b01000;
    end else begin
      spec_s       = 1'b0;
    end
  end

  logic [9:0]        frac_s;
  logic              guard_s, sticky_s, rnd_up_s;
  logic [10:0]       mant_sum_s;
  logic signed [6:0] exp_adj_s, exp_f_s;
  logic [15:0]       norm_res_s;
  logic [4:0]        norm_flags_s;

  // Normalise, round and range-check the quotient
  always_comb begin
    if (q[12]) begin
      frac_s    = q[11:2];
      guard_s   = q[1];
      sticky_s  = q[0] | (rem != 12'd0);
      exp_adj_s = exp_q;
    end else begin
      frac_s    = q[10:1];
      guard_s   = q[0];
      sticky_s  = (rem != 12'd0);
      exp_adj_s = exp_q - 7'sd1;
    end
`ifdef FP16_DIV_RNE_EN
    rnd_up_s = guard_s & (sticky_s | frac_s[0]);
`else
    rnd_up_s = 1'b0;
`endif
    mant_sum_s = {1'b0, frac_s} + {10'd0, rnd_up_s};
    exp_f_s    = exp_adj_s + $signed({6'd0, mant_sum_s[10]});
    if (exp_f_s >= 7'sd31) begin
      norm_res_s   = {sign_q, 5'h1F, 10'h000};
      norm_flags_s = 5'b10001;
    end else if (exp_f_s <= 7'sd0) begin
      norm_res_s   = {sign_q, 15'h0000};
      norm_flags_s = 5'b01001;
    end else begin
      norm_res_s   = {sign_q, exp_f_s[4:0], mant_sum_s[9:0]};
      norm_flags_s = {4'b0000, guard_s | sticky_s};
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= 16'h0000;
      flags      <= 5'b00000;
      op_a       <= 16'h0000;
      op_b       <= 16'h0000;
      rem        <= 12'd0;
      q          <= 13'd0;
      cnt        <= 4'd0;
      exp_q      <= 7'sd0;
      sign_q     <= 1'b0;
      spec_valid <= 1'b0;
      spec_res   <= 16'h0000;
      spec_flags <= 5'b00000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_a   <= a;
            op_b   <= b;
            busy   <= 1'b1;
            result <= 16'h0000;
            flags  <= 5'b00000;
            state  <= CHECK;
          end else begin
            state  <= IDLE;
          end
        end
        CHECK: begin
          sign_q     <= sgn_s;
          exp_q      <= $signed({2'b00, op_a[14:10]}) - $signed({2'b00, op_b[14:10]}) + 7'sd15;
          rem        <= {2'b01, op_a[9:0]};
          q          <= 13'd0;
          cnt        <= 4'd0;
          spec_valid <= spec_s;
          spec_res   <= spec_res_s;
          spec_flags <= spec_flags_s;
          state      <= DIVIDE;
        end
        DIVIDE: begin
          if (rem >= {1'b0, mb}) begin
            rem <= (rem - {1'b0, mb}) << 1;
            q   <= {q[11:0], 1'b1};
          end else begin
            rem <= rem << 1;
            q   <= {q[11:0], 1'b0};
          end
          cnt <= cnt + 4'd1;
          if (cnt == 4'd12) begin
            state <= ROUND;
          end else begin
            state <= DIVIDE;
          end
        end
        ROUND: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
          if (spec_valid) begin
            result <= spec_res;
            flags  <= spec_flags;
          end else begin
            result <= norm_res_s;
            flags  <= norm_flags_s;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_div_seq.sv
// Directed bench for fp16_div_seq: latency, busy window, quotient, flags, start gating and reset abort.
module tb_fp16_div_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] a, b;
  logic        busy, done, overflow, zero, nan, div_by_zero, precision_lost;
  logic [15:0] result;
  int          n_vec = 0;
  int          n_bad = 0;

  fp16_div_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .overflow(overflow), .zero(zero), .nan(nan),
    .div_by_zero(div_by_zero), .precision_lost(precision_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] flag_word();
    return {11'd0, overflow, zero, nan, div_by_zero, precision_lost};
  endfunction

  // Issues a request at the current negedge and follows it to done; stomp>0 re-pulses start mid-operation.
  task automatic do_op(input logic [15:0] xa, input logic [15:0] xb, input logic [15:0] er,
                       input logic [4:0] ef, input int stomp, input string tag);
    int cyc;
    int bcnt;
    a = xa; b = xb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    bcnt = 0;
    check({tag, "_clr"}, result, 16'h0000);
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      if (cyc == stomp) begin
        start = 1'b1; a = 16'h4000; b = 16'h4200;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_lat"}, 16'(cyc), 16'd16);
    check({tag, "_busycyc"}, 16'(bcnt), 16'd15);
    check({tag, "_busydone"}, {15'd0, busy}, 16'd0);
    check({tag, "_res"}, result, er);
    check({tag, "_flags"}, flag_word(), {11'd0, ef});
  endtask

  task automatic hold_check(input logic [15:0] er, input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_donelow"}, {15'd0, done}, 16'd0);
    check({tag, "_hold"}, result, er);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; start = 1'b0; a = 16'h0000; b = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_res", result, 16'h0000);
    check("rst_flags", flag_word(), 16'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(16'h4200, 16'hBE00, 16'hC000, 5'b00000, -1, "neg2");
    hold_check(16'hC000, "neg2");
    do_op(16'h3C00, 16'h4200, 16'h3555, 5'b00001, -1, "third");
    do_op(16'h4000, 16'h4200, 16'h3955, 5'b00001, -1, "twothird");
`ifdef FP16_DIV_RNE_EN
    do_op(16'h3C00, 16'h3BFF, 16'h3C01, 5'b00001, -1, "round");
`else
    do_op(16'h3C00, 16'h3BFF, 16'h3C00, 5'b00001, -1, "round");
`endif
    do_op(16'h3C00, 16'h0000, 16'h7C00, 5'b00010, -1, "divzero");
    do_op(16'h0000, 16'h0000, 16'h7E00, 5'b00100, -1, "zerozero");
    do_op(16'h7BFF, 16'h3800, 16'h7C00, 5'b10001, -1, "ovf");
    do_op(16'h0400, 16'h7800, 16'h0000, 5'b01001, -1, "unf");
    do_op(16'h7C00, 16'h4000, 16'h7C00, 5'b00000, -1, "infdiv");
    do_op(16'h7E01, 16'hBC00, 16'h7E00, 5'b00100, -1, "nanin");
    do_op(16'h3C00, 16'hFC00, 16'h8000, 5'b01000, -1, "byinf");
    do_op(16'h0001, 16'h3C00, 16'h0000, 5'b01000, -1, "subn");
    hold_check(16'h0000, "subn");

    do_op(16'h3C00, 16'h4200, 16'h3555, 5'b00001, 5, "stomp");
    // second request is issued in the DONE cycle of the first
    do_op(16'h4200, 16'hBE00, 16'hC000, 5'b00000, -1, "b2b_a");
    do_op(16'h3C00, 16'h4200, 16'h3555, 5'b00001, -1, "b2b_b");
    hold_check(16'h3555, "b2b_b");

    a = 16'h4200; b = 16'hBE00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {15'd0, busy}, 16'd0);
    check("abort_res", result, 16'h0000);
    check("abort_flags", flag_word(), 16'd0);
    seen = 1'b0;
    repeat (20) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_nodone", {15'd0, seen}, 16'd0);
    do_op(16'h4000, 16'h4200, 16'h3955, 5'b00001, -1, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
